// File: rtl/if_pd_queue.sv
// Purpose: DEPTH-entry fetch-to-predecode FIFO holding PC, PC+8, address error, delay-slot flag and predictor metadata.
// Latency: an entry pushed at edge N is visible on out_* after edge N (1 cycle min); no in-to-out bypass.
// Backpressure: in_ready = not full, independent of out_ready; refresh/bp_fail discard any same-cycle push or pop.
module if_pd_queue #(
    parameter int DEPTH  = 4,
    parameter int META_W = 40,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              refresh,
    input  logic              bp_fail,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic              in_addr_error,
    input  logic              in_is_branch,
    input  logic [META_W-1:0] in_meta,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_pc_8,
    output logic              out_addr_error,
    output logic              out_bd,
    output logic [META_W-1:0] out_meta,
    output logic              out_flushed,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    // Entry storage; one slot per queue position, addressed by head/tail.
    logic [31:0]       pc_mem     [DEPTH];
    logic [31:0]       pc_8_mem   [DEPTH];
    logic [META_W-1:0] meta_mem   [DEPTH];
    logic [DEPTH-1:0]  aerr_mem;
    logic [DEPTH-1:0]  bd_mem;

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count_q;
    logic              last_push_branch;
    logic              flushed_q;

    logic              flush;
    logic              push;
    logic              pop;

    // Handshake qualification: a flush cycle swallows both sides of the handshake.
    always_comb begin
        flush     = refresh | bp_fail;
        in_ready  = (count_q != CNT_W'(DEPTH));
        out_valid = (count_q != '0);
        push      = in_valid & in_ready & ~flush;
        pop       = out_valid & out_ready & ~flush;
    end

    // Payload write at the tail; PC+8 is precomputed here so PD gets it for free.
    // Storage is deliberately not cleared on flush, only on reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                pc_8_mem[i] <= '0;
                meta_mem[i] <= '0;
            end
            aerr_mem <= '0;
            bd_mem   <= '0;
        end else if (push) begin
            pc_mem[tail]   <= in_pc;
            pc_8_mem[tail] <= in_pc + 32'd8;
            meta_mem[tail] <= in_meta;
            aerr_mem[tail] <= in_addr_error;
            bd_mem[tail]   <= last_push_branch;
        end
    end

    // Delay-slot tracking: the entry that follows a branch in push order is its delay slot.
    // A flush breaks the sequence, so the next entry after a flush is never a delay slot.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            last_push_branch <= 1'b0;
        end else if (push) begin
            last_push_branch <= in_is_branch;
        end
    end

    // Tail pointer advances on each accepted push; wraps naturally (DEPTH is a power of two).
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            tail <= '0;
        end else if (push) begin
            tail <= tail + PTR_W'(1);
        end
    end

    // Head pointer advances on each accepted pop.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            head <= '0;
        end else if (pop) begin
            head <= head + PTR_W'(1);
        end
    end

    // Occupancy: +1 on push, -1 on pop, unchanged when both or neither happen.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // One-cycle echo of bp_fail for downstream stages; only reset overrides it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            flushed_q <= 1'b0;
        end else begin
            flushed_q <= bp_fail;
        end
    end

    // Head slot drives the payload outputs; stale when empty.
    always_comb begin
        out_pc         = pc_mem[head];
        out_pc_8       = pc_8_mem[head];
        out_meta       = meta_mem[head];
        out_addr_error = aerr_mem[head];
        out_bd         = bd_mem[head];
        out_flushed    = flushed_q;
        count          = count_q;
    end

endmodule

// File: tb/tb_if_pd_queue.sv
module tb_if_pd_queue;

    localparam int DEPTH  = 4;
    localparam int META_W = 40;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk;
    logic              resetn;
    logic              refresh;
    logic              bp_fail;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_pc;
    logic              in_addr_error;
    logic              in_is_branch;
    logic [META_W-1:0] in_meta;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic [31:0]       out_pc_8;
    logic              out_addr_error;
    logic              out_bd;
    logic [META_W-1:0] out_meta;
    logic              out_flushed;
    logic [CNT_W-1:0]  count;

    int vecs = 0;
    int errs = 0;

    if_pd_queue #(.DEPTH(DEPTH), .META_W(META_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .refresh(refresh), .bp_fail(bp_fail),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_addr_error(in_addr_error), .in_is_branch(in_is_branch), .in_meta(in_meta),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_pc_8(out_pc_8),
        .out_addr_error(out_addr_error), .out_bd(out_bd), .out_meta(out_meta),
        .out_flushed(out_flushed), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        refresh = 0; bp_fail = 0; in_valid = 0; in_pc = '0;
        in_addr_error = 0; in_is_branch = 0; in_meta = '0; out_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 0;
        tick(); tick();
        resetn = 1;
        vecs++; if (count !== 3'd0) begin errs++; $display("FAIL reset_count got %0d want 0", count); end
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        vecs++; if (out_flushed !== 1'b0) begin errs++; $display("FAIL reset_out_flushed got %b want 0", out_flushed); end
        vecs++; if ({out_pc, out_pc_8, out_meta, out_bd, out_addr_error} !== '0) begin
            errs++; $display("FAIL reset_payload got pc=%h pc8=%h meta=%h bd=%b ae=%b want all 0",
                             out_pc, out_pc_8, out_meta, out_bd, out_addr_error);
        end
    endtask

    task automatic test_basic();
        out_ready = 0;
        in_valid = 1; in_pc = 32'hBFC00000; in_meta = 40'h11_2233_4455; in_addr_error = 0;
        tick();
        vecs++; if (out_valid !== 1'b1 || out_pc !== 32'hBFC00000) begin
            errs++; $display("FAIL basic_latency got v=%b pc=%h want v=1 pc=bfc00000", out_valid, out_pc);
        end
        in_pc = 32'hBFC00004; in_meta = 40'hAA_BBCC_DDEE; in_addr_error = 1;
        tick();
        in_valid = 0; in_addr_error = 0;
        vecs++; if (count !== 3'd2) begin errs++; $display("FAIL basic_count got %0d want 2", count); end
        vecs++; if (out_pc !== 32'hBFC00000 || out_pc_8 !== 32'hBFC00008) begin
            errs++; $display("FAIL basic_head got pc=%h pc8=%h want bfc00000 bfc00008", out_pc, out_pc_8);
        end
        vecs++; if (out_meta !== 40'h11_2233_4455 || out_addr_error !== 1'b0) begin
            errs++; $display("FAIL basic_head_meta got meta=%h ae=%b want 1122334455 0", out_meta, out_addr_error);
        end
        out_ready = 1;
        tick();
        vecs++; if (out_pc !== 32'hBFC00004 || out_pc_8 !== 32'hBFC0000C || count !== 3'd1) begin
            errs++; $display("FAIL basic_second got pc=%h pc8=%h cnt=%0d want bfc00004 bfc0000c 1", out_pc, out_pc_8, count);
        end
        vecs++; if (out_meta !== 40'hAA_BBCC_DDEE || out_addr_error !== 1'b1) begin
            errs++; $display("FAIL basic_second_meta got meta=%h ae=%b want aabbccddee 1", out_meta, out_addr_error);
        end
        tick();
        vecs++; if (out_valid !== 1'b0 || count !== 3'd0) begin
            errs++; $display("FAIL basic_drain got v=%b cnt=%0d want 0 0", out_valid, count);
        end
        out_ready = 0;
    endtask

    task automatic test_full();
        out_ready = 0; in_valid = 1; in_meta = '0;
        for (int i = 0; i < 4; i++) begin
            in_pc = 32'h1000 + 32'(4 * i);
            tick();
        end
        vecs++; if (count !== 3'd4 || in_ready !== 1'b0) begin
            errs++; $display("FAIL full_state got cnt=%0d in_ready=%b want 4 0", count, in_ready);
        end
        in_pc = 32'h1010;
        tick();
        vecs++; if (count !== 3'd4 || out_pc !== 32'h1000) begin
            errs++; $display("FAIL full_reject got cnt=%0d pc=%h want 4 1000", count, out_pc);
        end
        // Pop while full with in_valid still high: no same-cycle push.
        out_ready = 1;
        tick();
        in_valid = 0; out_ready = 0;
        vecs++; if (count !== 3'd3 || in_ready !== 1'b1 || out_pc !== 32'h1004) begin
            errs++; $display("FAIL full_pop got cnt=%0d in_ready=%b pc=%h want 3 1 1004", count, in_ready, out_pc);
        end
        out_ready = 1;
        tick();
        vecs++; if (out_pc !== 32'h1008) begin errs++; $display("FAIL full_order1 got %h want 1008", out_pc); end
        tick();
        vecs++; if (out_pc !== 32'h100C) begin errs++; $display("FAIL full_order2 got %h want 100c", out_pc); end
        tick();
        vecs++; if (out_valid !== 1'b0 || count !== 3'd0) begin
            errs++; $display("FAIL full_drain got v=%b cnt=%0d want 0 0", out_valid, count);
        end
        out_ready = 0;
    endtask

    task automatic test_stream();
        logic [31:0] pcs [4];
        logic [31:0] pc8s [4];
        pcs[0] = 32'h2000;     pc8s[0] = 32'h2008;
        pcs[1] = 32'h2004;     pc8s[1] = 32'h200C;
        pcs[2] = 32'hFFFFFFFC; pc8s[2] = 32'h00000004;
        pcs[3] = 32'h2008;     pc8s[3] = 32'h2010;
        in_valid = 1; out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            in_pc = pcs[i];
            tick();
            vecs++; if (count !== 3'd1 || out_pc !== pcs[i] || out_pc_8 !== pc8s[i]) begin
                errs++; $display("FAIL stream_%0d got cnt=%0d pc=%h pc8=%h want 1 %h %h", i, count, out_pc, out_pc_8, pcs[i], pc8s[i]);
            end
        end
        in_valid = 0;
        tick();
        vecs++; if (count !== 3'd0) begin errs++; $display("FAIL stream_drain got %0d want 0", count); end
        out_ready = 0;
    endtask

    task automatic test_bd();
        logic exp_bd [3];
        exp_bd[0] = 0; exp_bd[1] = 1; exp_bd[2] = 0;
        out_ready = 0; in_valid = 1;
        in_pc = 32'h80000000; in_is_branch = 1; tick();
        in_pc = 32'h80000004; in_is_branch = 0; tick();
        in_pc = 32'h80000008; in_is_branch = 0; tick();
        in_valid = 0;
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            vecs++; if (out_bd !== exp_bd[i] || out_pc !== 32'h80000000 + 32'(4 * i)) begin
                errs++; $display("FAIL bd_%0d got bd=%b pc=%h want %b %h", i, out_bd, out_pc, exp_bd[i], 32'h80000000 + 32'(4 * i));
            end
            tick();
        end
        out_ready = 0;
        // Branch, then flush, then successor: successor is not a delay slot.
        in_valid = 1; in_pc = 32'h80000010; in_is_branch = 1; tick();
        in_valid = 0; in_is_branch = 0; refresh = 1; tick();
        refresh = 0;
        in_valid = 1; in_pc = 32'h80000014; tick();
        in_valid = 0;
        vecs++; if (out_bd !== 1'b0 || out_pc !== 32'h80000014 || count !== 3'd1) begin
            errs++; $display("FAIL bd_after_flush got bd=%b pc=%h cnt=%0d want 0 80000014 1", out_bd, out_pc, count);
        end
        out_ready = 1; tick(); out_ready = 0;
    endtask

    task automatic test_flush();
        for (int pass = 0; pass < 2; pass++) begin
            out_ready = 0; in_valid = 1;
            for (int i = 0; i < 3; i++) begin
                in_pc = 32'h3000 + 32'(4 * i);
                tick();
            end
            vecs++; if (count !== 3'd3) begin errs++; $display("FAIL flush_fill_%0d got %0d want 3", pass, count); end
            in_pc = 32'h3100; out_ready = 1;
            if (pass == 0) bp_fail = 1; else refresh = 1;
            tick();
            bp_fail = 0; refresh = 0; in_valid = 0; out_ready = 0;
            vecs++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errs++; $display("FAIL flush_clear_%0d got cnt=%0d v=%b rdy=%b want 0 0 1", pass, count, out_valid, in_ready);
            end
            vecs++; if (out_flushed !== (pass == 0)) begin
                errs++; $display("FAIL flush_flag_%0d got %b want %b", pass, out_flushed, pass == 0);
            end
            tick();
            vecs++; if (out_flushed !== 1'b0 || count !== 3'd0) begin
                errs++; $display("FAIL flush_flag_drop_%0d got fl=%b cnt=%0d want 0 0", pass, out_flushed, count);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 0; in_valid = 1; in_meta = 40'hDE_ADBE_EF01; in_addr_error = 1;
        in_pc = 32'h4000; in_is_branch = 0; tick();
        in_pc = 32'h4004; in_is_branch = 1; tick();
        resetn = 0; bp_fail = 1; out_ready = 1; in_pc = 32'h4008; in_is_branch = 0;
        tick();
        resetn = 1; bp_fail = 0; in_valid = 0; out_ready = 0; in_addr_error = 0; in_meta = '0;
        vecs++; if (count !== 3'd0 || out_flushed !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errs++; $display("FAIL rstmid_ctrl got cnt=%0d fl=%b rdy=%b v=%b want 0 0 1 0", count, out_flushed, in_ready, out_valid);
        end
        vecs++; if ({out_pc, out_pc_8, out_meta, out_bd, out_addr_error} !== '0) begin
            errs++; $display("FAIL rstmid_payload got pc=%h pc8=%h meta=%h bd=%b ae=%b want all 0",
                             out_pc, out_pc_8, out_meta, out_bd, out_addr_error);
        end
        // Branch history was cleared by reset: the next push is not a delay slot.
        in_valid = 1; in_pc = 32'h5000; tick();
        in_valid = 0;
        vecs++; if (out_bd !== 1'b0 || out_pc !== 32'h5000) begin
            errs++; $display("FAIL rstmid_bd got bd=%b pc=%h want 0 5000", out_bd, out_pc);
        end
    endtask

    initial begin
        resetn = 0;
        idle_inputs();
        test_reset();
        test_basic();
        test_full();
        test_stream();
        test_bd();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
